keypad_scanner: RTL

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 matrix keypad, debounces press and release, and reports
//   the accepted key as row_index*4 + col_index.
//
//   Build option: define KEYPAD_SYNC_EN to pass row_in through a two-flop
//   synchronizer (2 cycles of input latency). Otherwise row_in passes
//   through a single register (1 cycle of input latency).
//
// Parameters
//   SCAN_DIV         clk cycles each column is driven (4..65535)
//   DEBOUNCE_CYCLES  stable cycles needed to accept a press/release (2..2^20)
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous, active-low reset
//   row_in[3:0]  keypad rows, pulled up; low = key closed on driven column
//   col_out[3:0] column drive, active-low, exactly one bit low
//   key_pressed  debounced level, high while a key is accepted and held
//   key_valid    one-cycle pulse when a new press is accepted
//   key_code[3:0] last accepted key, row*4 + col
//   state_dbg[1:0] current FSM state (SCAN=0, DEBOUNCE=1, PRESSED=2, RELEASE=3)
module keypad_scanner #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic       key_pressed,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  // One shared counter serves as dwell counter in SCAN and as debounce
  // counter elsewhere; it is sized for the larger of the two limits.
  localparam int MAX_CNT = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam logic [CW-1:0] CNT_SAT    = '1;
  localparam logic [CW-1:0] DWELL_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYCLES - 1);

  // ---------------------------------------------------------------
  // Input stage; reset value all-high means "no key closed".
  // ---------------------------------------------------------------
  logic [3:0] rows;

`ifdef KEYPAD_SYNC_EN
  logic [3:0] row_meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_meta <= 4'hF;
      rows     <= 4'hF;
    end else begin
      row_meta <= row_in;
      rows     <= row_meta;
    end
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rows <= 4'hF;
    end else begin
      rows <= row_in;
    end
  end
`endif

  // ---------------------------------------------------------------
  // Lowest-index low row; iterating downward lets row 0 win.
  // ---------------------------------------------------------------
  logic       any_low;
  logic [1:0] low_idx;

  always_comb begin
    any_low = ~&rows;
    low_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows[i]) low_idx = 2'(i);
    end
  end

  // ---------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------
  state_t        state, state_d;
  logic [1:0]    col, col_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [1:0]    cap_row, cap_row_d;
  logic [3:0]    code_d;
  logic          valid_d;
  logic          cap_low;

  // Only the captured row on the frozen column is watched once a key is
  // captured; every other row is ignored.
  assign cap_low = ~rows[cap_row];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= SCAN;
      col       <= 2'd0;
      cnt       <= '0;
      cap_row   <= 2'd0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
    end else begin
      state     <= state_d;
      col       <= col_d;
      cnt       <= cnt_d;
      cap_row   <= cap_row_d;
      key_code  <= code_d;
      key_valid <= valid_d;
    end
  end

  always_comb begin
    state_d   = state;
    col_d     = col;
    cnt_d     = (cnt == CNT_SAT) ? cnt : cnt + 1'b1;
    cap_row_d = cap_row;
    code_d    = key_code;
    valid_d   = 1'b0;

    case (state)
      SCAN: begin
        // Rows are only looked at in the last dwell cycle, by which time
        // the input pipeline reflects the column currently driven.
        if (cnt >= DWELL_LAST) begin
          cnt_d = '0;
          if (any_low) begin
            cap_row_d = low_idx;
            state_d   = DEBOUNCE;
          end else begin
            col_d = col + 2'd1;
          end
        end
      end

      DEBOUNCE: begin
        if (!cap_low) begin
          state_d = SCAN;
          col_d   = col + 2'd1;
          cnt_d   = '0;
        end else if (cnt >= DEB_LAST) begin
          // key_valid and key_code land in the first PRESSED cycle,
          // the same cycle key_pressed rises.
          state_d = PRESSED;
          cnt_d   = '0;
          valid_d = 1'b1;
          code_d  = {cap_row, col};
        end
      end

      PRESSED: begin
        if (!cap_low) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end
      end

      RELEASE: begin
        if (cap_low) begin
          // Bounce while releasing: back to held, no new key_valid.
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt >= DEB_LAST) begin
          state_d = SCAN;
          col_d   = col + 2'd1;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = SCAN;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------
  assign col_out     = ~(4'b0001 << col);
  assign key_pressed = (state == PRESSED) || (state == RELEASE);
  assign state_dbg   = state;

endmodule
